// File: rtl/lsu_wait_state.sv
// Load-store unit with a variable-latency memory handshake and a bounded-wait timeout.
// Optional macro LSU_MISALIGN_TRAP_EN: fault misaligned accesses instead of aligning them down.
module lsu_wait_state #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   core_address,
    input  logic [DATA_WIDTH-1:0]   core_write_data,
    input  logic                    core_require,
    input  logic                    core_write_enable,
    input  logic [2:0]              core_size,
    output logic [DATA_WIDTH-1:0]   core_read_data,
    output logic                    core_stall_signal,
    output logic                    core_fault,
    input  logic [DATA_WIDTH-1:0]   memory_read_data,
    input  logic                    memory_ready,
    output logic                    memory_require,
    output logic                    memory_write_enable,
    output logic [DATA_WIDTH/8-1:0] memory_bytes_enable_map,
    output logic [ADDR_WIDTH-1:0]   memory_address,
    output logic [DATA_WIDTH-1:0]   memory_write_data
);

    localparam int unsigned NumBytes    = DATA_WIDTH / 8;
    localparam int unsigned OffW        = $clog2(NumBytes);
    localparam bit          HasD        = (DATA_WIDTH == 64);
    localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [NumBytes-1:0]   be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [OffW-1:0]       off_q, off_d;
    logic [2:0]            size_q, size_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  fault_q, fault_d;

    logic                  size_ok;
    logic                  req_legal;
    logic [OffW-1:0]       align_mask;
    logic [OffW-1:0]       req_off;
    logic [NumBytes-1:0]   req_be;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_data;

    // align_mask marks the offset bits that must be zero for a naturally aligned access
    always_comb begin
        size_ok    = 1'b1;
        align_mask = '0;
        case (core_size)
            3'b000, 3'b100: align_mask = '0;
            3'b001, 3'b101: align_mask = OffW'(1);
            3'b010:         align_mask = OffW'(3);
            3'b110: begin
                size_ok    = HasD;
                align_mask = OffW'(3);
            end
            3'b011: begin
                size_ok    = HasD;
                align_mask = '1;
            end
            default:        size_ok = 1'b0;
        endcase
        req_off = core_address[OffW-1:0] & ~align_mask;
`ifdef LSU_MISALIGN_TRAP_EN
        req_legal = size_ok & ~|(core_address[OffW-1:0] & align_mask);
`else
        req_legal = size_ok;
`endif
        case (core_size[1:0])
            2'b00: begin
                req_be    = NumBytes'(1) << req_off;
                req_wdata = {NumBytes{core_write_data[7:0]}};
            end
            2'b01: begin
                req_be    = NumBytes'(3) << req_off;
                req_wdata = {(NumBytes / 2){core_write_data[15:0]}};
            end
            2'b10: begin
                req_be    = NumBytes'(15) << req_off;
                req_wdata = {(NumBytes / 4){core_write_data[31:0]}};
            end
            default: begin
                req_be    = '1;
                req_wdata = core_write_data;
            end
        endcase
    end

    always_comb begin
        shifted = memory_read_data >> {off_q, 3'b000};
        case (size_q)
            3'b000:  load_data = DATA_WIDTH'($signed(shifted[7:0]));
            3'b001:  load_data = DATA_WIDTH'($signed(shifted[15:0]));
            3'b010:  load_data = DATA_WIDTH'($signed(shifted[31:0]));
            3'b100:  load_data = DATA_WIDTH'(shifted[7:0]);
            3'b101:  load_data = DATA_WIDTH'(shifted[15:0]);
            3'b110:  load_data = DATA_WIDTH'(shifted[31:0]);
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        off_d     = off_q;
        size_d    = size_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        case (state_q)
            StIdle: begin
                if (core_require) begin
                    if (req_legal) begin
                        addr_d    = {core_address[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
                        be_d      = req_be;
                        wdata_d   = req_wdata;
                        off_d     = req_off;
                        size_d    = core_size;
                        mem_req_d = 1'b1;
                        mem_we_d  = core_write_enable;
                        cnt_d     = '0;
                        rdata_d   = '0;
                        fault_d   = 1'b0;
                        state_d   = StWait;
                    end else begin
                        rdata_d = '0;
                        fault_d = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StWait: begin
                // ready is checked first so it wins over a timeout on the same cycle
                if (memory_ready) begin
                    rdata_d   = mem_we_q ? '0 : load_data;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    fault_d   = 1'b0;
                    state_d   = StDone;
                end else if (cnt_q == TimeoutLast) begin
                    rdata_d   = '0;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    fault_d   = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            off_q     <= '0;
            size_q    <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            off_q     <= off_d;
            size_q    <= size_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
        end
    end

    assign core_stall_signal       = core_require & (state_q != StDone);
    assign core_read_data          = rdata_q;
    assign core_fault              = fault_q;
    assign memory_require          = mem_req_q;
    assign memory_write_enable     = mem_we_q;
    assign memory_bytes_enable_map = be_q;
    assign memory_address          = addr_q;
    assign memory_write_data       = wdata_q;

endmodule

// File: tb/tb_lsu_wait_state.sv
// Self-checking bench for lsu_wait_state: a 32-bit and a 64-bit instance checked against
// a byte-level reference model under directed and random accesses.
module tb_lsu_wait_state;

    localparam int ToA = 4;
    localparam int ToB = 6;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [63:0] wd, rd;
    logic        req_a, req_b, we, ready, sel;
    logic [2:0]  size;

    logic [31:0] a_rdata, a_maddr, a_mwdata;
    logic [3:0]  a_map;
    logic        a_stall, a_fault, a_mreq, a_mwe;
    logic [63:0] b_rdata, b_mwdata;
    logic [31:0] b_maddr;
    logic [7:0]  b_map;
    logic        b_stall, b_fault, b_mreq, b_mwe;

    logic [63:0] o_rdata, o_mwdata;
    logic [31:0] o_maddr;
    logic [7:0]  o_map;
    logic        o_stall, o_fault, o_mreq, o_mwe;

    int n_checks;
    int n_pass;

    lsu_wait_state #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(ToA)) u_dut_a (
        .clk(clk), .reset(reset), .core_address(addr), .core_write_data(wd[31:0]),
        .core_require(req_a), .core_write_enable(we), .core_size(size),
        .core_read_data(a_rdata), .core_stall_signal(a_stall), .core_fault(a_fault),
        .memory_read_data(rd[31:0]), .memory_ready(ready), .memory_require(a_mreq),
        .memory_write_enable(a_mwe), .memory_bytes_enable_map(a_map),
        .memory_address(a_maddr), .memory_write_data(a_mwdata)
    );

    lsu_wait_state #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(ToB)) u_dut_b (
        .clk(clk), .reset(reset), .core_address(addr), .core_write_data(wd),
        .core_require(req_b), .core_write_enable(we), .core_size(size),
        .core_read_data(b_rdata), .core_stall_signal(b_stall), .core_fault(b_fault),
        .memory_read_data(rd), .memory_ready(ready), .memory_require(b_mreq),
        .memory_write_enable(b_mwe), .memory_bytes_enable_map(b_map),
        .memory_address(b_maddr), .memory_write_data(b_mwdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (sel) begin
            o_rdata = b_rdata; o_mwdata = b_mwdata; o_maddr = b_maddr; o_map = b_map;
            o_stall = b_stall; o_fault = b_fault; o_mreq = b_mreq; o_mwe = b_mwe;
        end else begin
            o_rdata = {32'b0, a_rdata}; o_mwdata = {32'b0, a_mwdata}; o_maddr = a_maddr;
            o_map = {4'b0, a_map}; o_stall = a_stall; o_fault = a_fault; o_mreq = a_mreq;
            o_mwe = a_mwe;
        end
    end

    // Reference model: byte-level view of one access on a dw-bit bus.
    task automatic model(input int dw, input int to, input logic [31:0] a, input logic [2:0] sz,
                         input logic w, input logic [63:0] wdat, input logic [63:0] rdat,
                         input int dly, input bit never,
                         output bit e_legal, output bit e_fault, output logic [63:0] e_rdata,
                         output logic [31:0] e_maddr, output logic [7:0] e_map,
                         output logic [63:0] e_wdata, output int e_waits);
        int nb, off, bytes, eff;
        logic [63:0] mask, dmask, v;
        nb = dw / 8;
        off = int'(a % nb);
        case (sz)
            3'd0, 3'd4: bytes = 1;
            3'd1, 3'd5: bytes = 2;
            3'd2, 3'd6: bytes = 4;
            default:    bytes = 8;
        endcase
        e_legal = (sz != 3'd7) && (dw == 64 || (sz != 3'd3 && sz != 3'd6));
`ifdef LSU_MISALIGN_TRAP_EN
        if (off % bytes != 0) e_legal = 1'b0;
`endif
        eff = off - (off % bytes);
        mask = (bytes == 8) ? '1 : ((64'd1 << (8 * bytes)) - 64'd1);
        dmask = (dw == 64) ? '1 : 64'hFFFF_FFFF;
        e_maddr = a - 32'(off);
        e_map = 8'(((1 << bytes) - 1) << eff);
        e_wdata = '0;
        for (int i = 0; i < nb / bytes; i++) e_wdata = e_wdata | ((wdat & mask) << (i * bytes * 8));
        e_wdata = e_wdata & dmask;
        v = ((rdat & dmask) >> (8 * eff)) & mask;
        if (sz < 3'd4 && v[8 * bytes - 1]) v = v | ~mask;
        v = v & dmask;
        if (!e_legal) e_waits = 0;
        else if (never || dly >= to) e_waits = to;
        else e_waits = dly + 1;
        e_fault = !e_legal || never || dly >= to;
        e_rdata = (e_fault || w) ? 64'd0 : v;
    endtask

    // Drives one access starting at the current negedge and checks it at its DONE cycle.
    task automatic run(input bit s, input logic [31:0] a, input logic [2:0] sz, input logic w,
                       input logic [63:0] wdat, input logic [63:0] rdat, input int dly,
                       input bit never, input bit keep, input string tag);
        bit e_legal, e_fault, done;
        logic [63:0] e_rdata, e_wdata, c_wdata;
        logic [31:0] e_maddr, c_maddr;
        logic [7:0]  e_map, c_map;
        int e_waits, stall_n, mreq_n, mwe_n;
        model(s ? 64 : 32, s ? ToB : ToA, a, sz, w, wdat, rdat, dly, never,
              e_legal, e_fault, e_rdata, e_maddr, e_map, e_wdata, e_waits);
        sel = s; addr = a; size = sz; we = w; wd = wdat; rd = rdat;
        req_a = !s; req_b = s;
        ready = 1'($urandom);
        stall_n = 0; mreq_n = 0; mwe_n = 0; done = 0;
        c_wdata = '0; c_maddr = '0; c_map = '0;
        #1;
        for (int c = 0; c < 64 && !done; c++) begin
            if (!o_stall) done = 1;
            else begin
                stall_n++;
                if (c > 0) ready = !never && (c - 1 == dly);
                @(negedge clk);
                if (o_mreq) begin
                    if (mreq_n == 0) begin
                        c_maddr = o_maddr; c_map = o_map; c_wdata = o_mwdata;
                    end
                    mreq_n++;
                end
                if (o_mwe) mwe_n++;
            end
        end
        n_checks++;
        if (!done) $display("FAIL %s release: stall still high after 64 cycles, exp low", tag);
        else n_pass++;
        n_checks++;
        if (stall_n != 1 + e_waits) $display("FAIL %s stall_cycles got %0d exp %0d", tag, stall_n,
                                              1 + e_waits);
        else n_pass++;
        n_checks++;
        if (o_fault !== e_fault) $display("FAIL %s fault got %0b exp %0b", tag, o_fault, e_fault);
        else n_pass++;
        n_checks++;
        if (o_rdata !== e_rdata) $display("FAIL %s read_data got %h exp %h", tag, o_rdata, e_rdata);
        else n_pass++;
        n_checks++;
        if (mreq_n != e_waits) $display("FAIL %s mreq_cycles got %0d exp %0d", tag, mreq_n, e_waits);
        else n_pass++;
        n_checks++;
        if (mwe_n != (w ? e_waits : 0))
            $display("FAIL %s mwe_cycles got %0d exp %0d", tag, mwe_n, w ? e_waits : 0);
        else n_pass++;
        n_checks++;
        if (o_mreq !== 1'b0) $display("FAIL %s mreq_in_done got %0b exp 0", tag, o_mreq);
        else n_pass++;
        if (e_legal) begin
            n_checks++;
            if (c_maddr !== e_maddr) $display("FAIL %s maddr got %h exp %h", tag, c_maddr, e_maddr);
            else n_pass++;
            n_checks++;
            if (c_map !== e_map) $display("FAIL %s map got %b exp %b", tag, c_map, e_map);
            else n_pass++;
            n_checks++;
            if (c_wdata !== e_wdata) $display("FAIL %s mwdata got %h exp %h", tag, c_wdata, e_wdata);
            else n_pass++;
        end
        ready = 1'($urandom);
        if (!keep) begin
            req_a = 1'b0; req_b = 1'b0;
        end
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_a = 0; req_b = 0; we = 0; ready = 0; sel = 0;
        addr = '0; wd = '0; rd = '0; size = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_stall, a_fault, a_mreq, a_mwe} !== 4'b0)
            $display("FAIL reset_a_ctrl got %b exp 0000", {a_stall, a_fault, a_mreq, a_mwe});
        else n_pass++;
        n_checks++;
        if ({a_map, a_maddr} !== '0) $display("FAIL reset_a_map_addr got %h exp 0", {a_map, a_maddr});
        else n_pass++;
        n_checks++;
        if ({a_mwdata, a_rdata} !== '0) $display("FAIL reset_a_data got %h exp 0", {a_mwdata, a_rdata});
        else n_pass++;
        n_checks++;
        if ({b_stall, b_fault, b_mreq, b_mwe} !== 4'b0)
            $display("FAIL reset_b_ctrl got %b exp 0000", {b_stall, b_fault, b_mreq, b_mwe});
        else n_pass++;
        n_checks++;
        if ({b_map, b_maddr} !== '0) $display("FAIL reset_b_map_addr got %h exp 0", {b_map, b_maddr});
        else n_pass++;
        n_checks++;
        if ({b_mwdata, b_rdata} !== '0) $display("FAIL reset_b_data got %h exp 0", {b_mwdata, b_rdata});
        else n_pass++;
    endtask

    task automatic test_directed();
        run(0, 32'h104, 3'b010, 0, '0, 64'hDEADBEEF, 0, 0, 0, "lw");
        run(0, 32'h203, 3'b000, 0, '0, 64'h80123456, 1, 0, 0, "lb");
        run(0, 32'h203, 3'b100, 0, '0, 64'h80123456, 2, 0, 0, "lbu");
        run(0, 32'h12, 3'b001, 1, 64'h0000ABCD, {$urandom, $urandom}, 3, 0, 0, "sh");
        run(0, 32'h80, 3'b010, 0, '0, {$urandom, $urandom}, 0, 1, 0, "timeout");
        run(0, 32'h84, 3'b001, 0, '0, 64'h1234F678, ToA - 1, 0, 0, "ready_at_timeout");
        run(0, 32'h101, 3'b010, 0, '0, 64'h01020304, 0, 0, 0, "lw_misaligned");
        run(0, 32'h40, 3'b011, 0, '0, 64'h55, 0, 0, 0, "ld_on_32");
        run(1, 32'h0C, 3'b110, 0, '0, 64'h89ABCDEF_00000000, 0, 0, 0, "lwu64");
        run(1, 32'h08, 3'b011, 1, 64'h0123456789ABCDEF, '0, 2, 0, 0, "sd64");
        run(1, 32'h0D, 3'b010, 0, '0, 64'h80000000_11223344, 0, 0, 0, "lw64_misaligned");
        run(1, 32'h10, 3'b111, 0, '0, '0, 0, 0, 0, "illegal_size");
        run(1, 32'h18, 3'b001, 0, '0, '0, 0, 1, 0, "timeout64");
    endtask

    task automatic test_back_to_back();
        run(0, 32'h300, 3'b010, 0, '0, 64'hCAFEF00D, 0, 0, 1, "b2b_a0");
        run(0, 32'h302, 3'b101, 0, '0, 64'h8001FFFF, 1, 0, 1, "b2b_a1");
        run(0, 32'h301, 3'b000, 1, 64'h5A, '0, 0, 0, 0, "b2b_a2");
        run(1, 32'h400, 3'b011, 0, '0, 64'hFEDCBA98_76543210, 0, 0, 1, "b2b_b0");
        run(1, 32'h407, 3'b000, 0, '0, 64'h80000000_00000000, 0, 0, 0, "b2b_b1");
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            run(1'($urandom), $urandom & 32'hFFFF, 3'($urandom_range(0, 7)), 1'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 7)),
                ($urandom % 8) == 0, 1'($urandom), "random");
        end
        req_a = 0; req_b = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        sel = 1; addr = 32'h40; size = 3'b011; we = 1; wd = {$urandom, $urandom}; rd = '0;
        req_a = 0; req_b = 1; ready = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({b_mreq, b_mwe} !== 2'b11) $display("FAIL rst_mid_pre got %b exp 11", {b_mreq, b_mwe});
        else n_pass++;
        reset = 1; ready = 1;
        @(negedge clk);
        n_checks++;
        if ({b_mreq, b_mwe, b_fault} !== 3'b000)
            $display("FAIL rst_mid_ctrl got %b exp 000", {b_mreq, b_mwe, b_fault});
        else n_pass++;
        n_checks++;
        if ({b_map, b_maddr, b_mwdata, b_rdata} !== '0)
            $display("FAIL rst_mid_data got %h exp 0", {b_map, b_maddr, b_mwdata, b_rdata});
        else n_pass++;
        n_checks++;
        if (b_stall !== 1'b1) $display("FAIL rst_mid_stall_idle got %b exp 1", b_stall);
        else n_pass++;
        reset = 0; req_b = 0;
        @(negedge clk);
        n_checks++;
        if ({b_mreq, b_stall} !== 2'b00) $display("FAIL rst_mid_after got %b exp 00", {b_mreq, b_stall});
        else n_pass++;
        ready = 0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        run(0, 32'h500, 3'b010, 0, '0, 64'h7FFF0001, 0, 0, 0, "post_reset");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
